// File: rtl/isa_pkg.sv
// Shared ISA constants, FSM state type and opcode decode helper for the issue stage.
package isa_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned RF_DEPTH = 8;
    localparam int unsigned RF_AW    = 3;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned OP_W     = 5;
    localparam int unsigned APSR_W   = 4;
    localparam int unsigned BYTE_W   = 8;

    localparam logic [SEL_W-1:0] SEL_ADD = 3'b000;
    localparam logic [SEL_W-1:0] SEL_SUB = 3'b101;
    localparam logic [SEL_W-1:0] SEL_MVI = 3'b001;
    localparam logic [SEL_W-1:0] SEL_MVR = 3'b010;
    localparam logic [SEL_W-1:0] SEL_NOP = 3'b111;

    localparam logic [OP_W-1:0] OP_MOVS = 5'b00100;
    localparam logic [OP_W-1:0] OP_CMP  = 5'b00101;
    localparam logic [OP_W-1:0] OP_ADDS = 5'b00110;
    localparam logic [OP_W-1:0] OP_SUBS = 5'b00111;
    localparam logic [OP_W-1:0] OP_MOVR = 5'b01000;

    localparam int unsigned APSR_N = 3;
    localparam int unsigned APSR_Z = 2;
    localparam int unsigned APSR_C = 1;
    localparam int unsigned APSR_V = 0;

    typedef enum logic [1:0] {
        S_HI   = 2'd0,
        S_LO   = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    // Per-opcode control bundle.
    typedef struct packed {
        logic             legal;
        logic [SEL_W-1:0] sel;
        logic             use_rn;     // drive Rn from the register file
        logic             rn_from_rm; // Rn indexed by lo[2:0] instead of rd
        logic             wr_en;      // result written back to rd
    } dec_t;

    // Map an opcode onto its control bundle; unknown opcodes come back illegal.
    function automatic dec_t decode(input logic [OP_W-1:0] op);
        dec_t d;
        d = '{legal: 1'b0, sel: SEL_NOP, use_rn: 1'b0, rn_from_rm: 1'b0, wr_en: 1'b0};
        case (op)
            OP_MOVS: d = '{legal: 1'b1, sel: SEL_MVI, use_rn: 1'b0, rn_from_rm: 1'b0, wr_en: 1'b1};
            OP_CMP:  d = '{legal: 1'b1, sel: SEL_SUB, use_rn: 1'b1, rn_from_rm: 1'b0, wr_en: 1'b0};
            OP_ADDS: d = '{legal: 1'b1, sel: SEL_ADD, use_rn: 1'b1, rn_from_rm: 1'b0, wr_en: 1'b1};
            OP_SUBS: d = '{legal: 1'b1, sel: SEL_SUB, use_rn: 1'b1, rn_from_rm: 1'b0, wr_en: 1'b1};
            OP_MOVR: d = '{legal: 1'b1, sel: SEL_MVR, use_rn: 1'b1, rn_from_rm: 1'b1, wr_en: 1'b1};
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile8x32.sv
// 8x32 register file: one write port, operand and debug combinational read ports.
module regfile8x32
    import isa_pkg::*;
#(
    parameter logic [XLEN-1:0] RF_RESET = 32'h0000_0000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [RF_AW-1:0] i_waddr,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [RF_AW-1:0] i_raddr,
    output logic [XLEN-1:0]  o_rdata,
    input  logic [RF_AW-1:0] i_dbg_addr,
    output logic [XLEN-1:0]  o_dbg_data
);

    logic [XLEN-1:0] mem_q [RF_DEPTH];

    // Storage with synchronous reset of every entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(RF_DEPTH); i++) begin
                mem_q[i] <= RF_RESET;
            end
        end else if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata    = mem_q[i_raddr];
    assign o_dbg_data = mem_q[i_dbg_addr];

endmodule

// File: rtl/instr_decode.sv
// Byte-serial decode/issue stage feeding an external combinational ALU.
module instr_decode
    import isa_pkg::*;
#(
    parameter logic [XLEN-1:0] RF_RESET = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic [XLEN-1:0]   o_alu_imm,
    output logic [XLEN-1:0]   o_alu_rn,
    output logic [SEL_W-1:0]  o_alu_sel,
    input  logic [XLEN-1:0]   i_alu_result,
    input  logic [APSR_W-1:0] i_alu_apsr,
    output logic [APSR_W-1:0] o_apsr,
    output logic              o_retire,
    output logic              o_err,
    input  logic [RF_AW-1:0]  i_dbg_addr,
    output logic [XLEN-1:0]   o_dbg_data
);

    state_t             state_q;
    state_t             state_d;
    logic [BYTE_W-1:0]  hi_q;
    dec_t               dec;
    logic               xfer;
    logic               hi_load;
    logic               lo_xfer;
    logic               rf_we;
    logic [RF_AW-1:0]   rd_addr;
    logic [XLEN-1:0]    rf_rdata;

    regfile8x32 #(.RF_RESET(RF_RESET)) u_rf (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_we       (rf_we),
        .i_waddr    (hi_q[RF_AW-1:0]),
        .i_wdata    (i_alu_result),
        .i_raddr    (rd_addr),
        .o_rdata    (rf_rdata),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and byte-acceptance control; decode always looks at the latched hi byte.
    always_comb begin
        state_d = state_q;
        hi_load = 1'b0;
        lo_xfer = 1'b0;
        dec     = decode(hi_q[BYTE_W-1:RF_AW]);
        xfer    = i_byte_valid && o_byte_ready;
        case (state_q)
            S_HI: begin
                if (xfer) begin
                    hi_load = 1'b1;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_xfer = 1'b1;
                    state_d = dec.legal ? S_EXEC : S_HI;
                end
            end
            S_EXEC:  state_d = S_HI;
            default: state_d = S_HI;
        endcase
        rf_we   = (state_q == S_EXEC) && dec.wr_en;
        rd_addr = dec.rn_from_rm ? i_byte[RF_AW-1:0] : hi_q[RF_AW-1:0];
    end

    // Registered outputs: operands loaded as the lo byte lands, held for the exec cycle only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hi_q         <= '0;
            o_byte_ready <= 1'b1;
            o_alu_imm    <= '0;
            o_alu_rn     <= '0;
            o_alu_sel    <= SEL_NOP;
            o_apsr       <= '0;
            o_retire     <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_byte_ready <= (state_d != S_EXEC);
            o_retire     <= (state_q == S_EXEC);
            o_err        <= lo_xfer && !dec.legal;
            if (hi_load) begin
                hi_q <= i_byte;
            end
            if (lo_xfer && dec.legal) begin
                o_alu_imm <= XLEN'(i_byte);
                o_alu_rn  <= dec.use_rn ? rf_rdata : '0;
                o_alu_sel <= dec.sel;
            end else if (state_q == S_EXEC) begin
                o_alu_imm <= '0;
                o_alu_rn  <= '0;
                o_alu_sel <= SEL_NOP;
            end
            if (state_q == S_EXEC) begin
                o_apsr <= i_alu_apsr;
            end
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode with a behavioural ALU closing the loop.
`timescale 1ns/1ps
module tb_instr_decode;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] alu_imm;
    logic [31:0] alu_rn;
    logic [2:0]  alu_sel;
    logic [31:0] alu_result;
    logic [3:0]  alu_apsr;
    logic [3:0]  apsr;
    logic        retire;
    logic        err;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_cmp;
    int n_bad;

    instr_decode #(.RF_RESET(32'h0000_0000)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_byte       (byte_in),
        .i_byte_valid (byte_valid),
        .o_byte_ready (byte_ready),
        .o_alu_imm    (alu_imm),
        .o_alu_rn     (alu_rn),
        .o_alu_sel    (alu_sel),
        .i_alu_result (alu_result),
        .i_alu_apsr   (alu_apsr),
        .o_apsr       (apsr),
        .o_retire     (retire),
        .o_err        (err),
        .i_dbg_addr   (dbg_addr),
        .o_dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: flags {N,Z,C,V}, C is no-borrow on subtract, moves clear C and V.
    always_comb begin
        logic [32:0] s;
        logic        c;
        logic        v;
        s = '0;
        c = 1'b0;
        v = 1'b0;
        case (alu_sel)
            3'b000: begin
                s = {1'b0, alu_rn} + {1'b0, alu_imm};
                c = s[32];
                v = (alu_rn[31] == alu_imm[31]) && (s[31] != alu_rn[31]);
            end
            3'b101: begin
                s = {1'b0, alu_rn} + {1'b0, ~alu_imm} + 33'd1;
                c = s[32];
                v = (alu_rn[31] != alu_imm[31]) && (s[31] != alu_rn[31]);
            end
            3'b001:  s = {1'b0, alu_imm};
            3'b010:  s = {1'b0, alu_rn};
            default: s = '0;
        endcase
        alu_result = s[31:0];
        if (alu_sel == 3'b111) alu_apsr = 4'b0000;
        else alu_apsr = {s[31], (s[31:0] == 32'd0), c, v};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte; returns 1ns after the edge that transfers it.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        while (!byte_ready && waited < 20) begin
            step();
            waited++;
        end
        check("ready_timeout", 32'(byte_ready), 32'd1);
        byte_in    = b;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
    endtask

    // Send a legal instruction and check its exec cycle and retirement.
    task automatic run_legal(input string tag, input logic [7:0] hi, input logic [7:0] lo);
        send_byte(hi);
        send_byte(lo);
        check({tag, "_exec_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_exec_noretire"}, 32'(retire), 32'd0);
        step();
        check({tag, "_retire"}, 32'(retire), 32'd1);
        check({tag, "_noerr"}, 32'(err), 32'd0);
    endtask

    task automatic rf_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        dbg_addr = a;
        @(negedge clk);
        check(tag, dbg_data, exp);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        dbg_addr   = 3'd0;
        step();
        step();
        rst = 1'b0;

        // Reset values
        check("rst_ready", 32'(byte_ready), 32'd1);
        check("rst_apsr", 32'(apsr), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_sel", 32'(alu_sel), 32'd7);
        check("rst_imm", alu_imm, 32'd0);
        check("rst_rn", alu_rn, 32'd0);

        // 1: MOVS r1,#0x5A
        send_byte(8'h21);
        send_byte(8'h5A);
        check("movs_sel", 32'(alu_sel), 32'd1);
        check("movs_imm", alu_imm, 32'h5A);
        check("movs_ready", 32'(byte_ready), 32'd0);
        step();
        check("movs_retire", 32'(retire), 32'd1);
        check("movs_apsr", 32'(apsr), 32'b0000);
        check("movs_idle_sel", 32'(alu_sel), 32'd7);
        step();
        check("movs_retire_pulse", 32'(retire), 32'd0);
        rf_check("movs_r1", 3'd1, 32'h5A);

        // 2: r2 = 0 - 1, then ADDS r2,#1 wraps to zero
        run_legal("movs_r2", 8'h22, 8'h00);
        check("movs_r2_apsr", 32'(apsr), 32'b0100);
        run_legal("subs", 8'h3A, 8'h01);
        check("subs_apsr", 32'(apsr), 32'b1000);
        rf_check("subs_r2", 3'd2, 32'hFFFF_FFFF);
        run_legal("adds", 8'h32, 8'h01);
        check("adds_apsr", 32'(apsr), 32'b0110);
        rf_check("adds_r2", 3'd2, 32'h0000_0000);

        // 3: CMP r3,#7 with r3=5
        run_legal("movs_r3", 8'h23, 8'h05);
        send_byte(8'h2B);
        send_byte(8'h07);
        check("cmp_sel", 32'(alu_sel), 32'd5);
        check("cmp_rn", alu_rn, 32'd5);
        check("cmp_imm", alu_imm, 32'd7);
        step();
        check("cmp_retire", 32'(retire), 32'd1);
        check("cmp_apsr", 32'(apsr), 32'b1000);
        rf_check("cmp_r3", 3'd3, 32'd5);

        // 4: MOV r4,r1
        send_byte(8'h44);
        send_byte(8'h01);
        check("movr_sel", 32'(alu_sel), 32'd2);
        check("movr_rn", alu_rn, 32'h5A);
        step();
        check("movr_retire", 32'(retire), 32'd1);
        check("movr_apsr", 32'(apsr), 32'b0000);
        rf_check("movr_r4", 3'd4, 32'h5A);

        // 5: illegal opcode 0xF8
        send_byte(8'hF8);
        send_byte(8'h00);
        check("ill_err", 32'(err), 32'd1);
        check("ill_noretire", 32'(retire), 32'd0);
        check("ill_ready", 32'(byte_ready), 32'd1);
        check("ill_sel", 32'(alu_sel), 32'd7);
        step();
        check("ill_err_pulse", 32'(err), 32'd0);
        check("ill_noretire2", 32'(retire), 32'd0);
        check("ill_apsr", 32'(apsr), 32'b0000);
        rf_check("ill_r0", 3'd0, 32'd0);
        rf_check("ill_r1", 3'd1, 32'h5A);
        rf_check("ill_r4", 3'd4, 32'h5A);

        // 6a: stall between hi and lo
        send_byte(8'h25);
        repeat (4) step();
        check("stall_ready", 32'(byte_ready), 32'd1);
        check("stall_noretire", 32'(retire), 32'd0);
        send_byte(8'h10);
        step();
        check("stall_retire", 32'(retire), 32'd1);
        rf_check("stall_r5", 3'd5, 32'h10);

        // 6b: reset while waiting for the lo byte, with a lo byte offered in the same cycle
        send_byte(8'h25);
        byte_in    = 8'h77;
        byte_valid = 1'b1;
        rst        = 1'b1;
        step();
        rst        = 1'b0;
        byte_valid = 1'b0;
        check("rmid_ready", 32'(byte_ready), 32'd1);
        check("rmid_apsr", 32'(apsr), 32'd0);
        check("rmid_sel", 32'(alu_sel), 32'd7);
        step();
        check("rmid_noretire", 32'(retire), 32'd0);
        check("rmid_noerr", 32'(err), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rf_check($sformatf("rmid_r%0d", i), 3'(i), 32'd0);
        end
        // Back in S_HI: a fresh instruction decodes from its own hi byte
        run_legal("post_rst", 8'h26, 8'h33);
        rf_check("post_rst_r6", 3'd6, 32'h33);
        rf_check("post_rst_r5", 3'd5, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_decode.md
# instr_decode

Byte-serial instruction decode and issue stage that sits directly upstream of the combinational ALU. It assembles 16-bit instructions from a byte stream, reads operands from an internal 8×32 register file, and drives the ALU operand and select inputs. It then writes the ALU result back and latches the ALU flags into an architectural APSR register.

## Interface
Parameters:
- `RF_RESET`, default `32'h0000_0000`: value loaded into every register-file entry on reset.

Ports:
- `i_clk`, in, 1: clock. One clock domain; all state updates on the rising edge.
- `i_rst`, in, 1: reset. Synchronous, active-high.
- `i_byte`, in, 8: instruction byte. The high byte comes first.
- `i_byte_valid`, in, 1: `i_byte` is valid.
- `o_byte_ready`, out, 1: the block accepts a byte. A byte transfers on any cycle where `i_byte_valid` and `o_byte_ready` are both high.
- `o_alu_imm`, out, 32: ALU immediate operand.
- `o_alu_rn`, out, 32: ALU register operand.
- `o_alu_sel`, out, 3: ALU operation select. `000` add, `101` sub, `001` mv imm, `010` mv reg.
- `i_alu_result`, in, 32: ALU result (combinational return).
- `i_alu_apsr`, in, 4: ALU flags {N,Z,C,V}.
- `o_apsr`, out, 4: architectural flags {N,Z,C,V}.
- `o_retire`, out, 1: one-cycle pulse when a legal instruction completes.
- `o_err`, out, 1: one-cycle pulse when an illegal opcode is dropped.
- `i_dbg_addr`, in, 3: debug read address.
- `o_dbg_data`, out, 32: combinational read of `RF[i_dbg_addr]`.

## Operation
**Encoding.** The instruction is {hi, lo}.
- `op = hi[7:3]`, `rd = hi[2:0]`.
- `imm = {24'b0, lo}`, zero-extended.
- `rm = lo[2:0]`.

**Opcodes.**
- `00100` MOVS: sel `001`; writes `rd`.
- `00101` CMP: sel `101`, Rn = `RF[rd]`; no write.
- `00110` ADDS: sel `000`, Rn = `RF[rd]`; writes `rd`.
- `00111` SUBS: sel `101`, Rn = `RF[rd]`; writes `rd`.
- `01000` MOV reg: sel `010`, Rn = `RF[rm]`; writes `rd`.
- Any other `op` is illegal.

**FSM states.**
- `S_HI`: `o_byte_ready`=1. On transfer, latch hi and go to `S_LO`.
- `S_LO`: `o_byte_ready`=1. On transfer, latch lo and decode.
  - Legal opcode: go to `S_EXEC`.
  - Illegal opcode: set `o_err` next cycle and go to `S_HI`. The lo byte is still consumed.
- `S_EXEC`: `o_byte_ready`=0.
  - Drive ALU operands from the latched decode.
  - At the cycle's closing edge, write `i_alu_result` to `RF[rd]` (unless CMP) and load `o_apsr` from `i_alu_apsr`. All legal ops update APSR.
  - Set `o_retire` for the next cycle and go to `S_HI`.

**Operand outputs.**
- Outside `S_EXEC`: `o_alu_imm`=0, `o_alu_rn`=0, `o_alu_sel`=`111`. The ALU default then yields 0.

**Arithmetic.**
- The 32-bit result wraps. No sign extension of the immediate.
- C and V are taken from the ALU as delivered.

**Register file.**
- Single write port, written only in `S_EXEC`.
- `o_dbg_data` shows the new value from the cycle after the write.

## Timing
**Reset values.**
- State `S_HI`; `o_byte_ready`=1.
- All RF entries = `RF_RESET`.
- `o_apsr`=`4'b0000`; `o_retire`=0; `o_err`=0.
- ALU outputs at idle values.

**Reset mid-instruction.** Discard any latched hi/lo byte; do not write RF or APSR. Reset has priority over any transfer in the same cycle.

**Latency.**
- The lo byte is accepted at cycle t; `S_EXEC` is cycle t+1.
- The RF and APSR update is visible at t+2, and `o_retire`=1 at t+2.
- An illegal opcode gives `o_err`=1 at t+1.

**Throughput.**
- Legal instructions: at most 1 instruction per 3 cycles with back-to-back bytes.
- Illegal instructions: 2 cycles each.

**Handshake.**
- `i_byte_valid` may drop between the hi and lo bytes. The block waits in `S_LO` indefinitely.
- A byte offered during `S_EXEC` is not consumed.

**Pulses.** `o_retire` and `o_err` never assert in the same cycle.

## Structure
**Shared package `isa_pkg`:**
- ALU select constants (`SEL_ADD`, `SEL_SUB`, `SEL_MVI`, `SEL_MVR`, `SEL_NOP`).
- Opcode constants (`OP_MOVS`, `OP_CMP`, `OP_ADDS`, `OP_SUBS`, `OP_MOVR`).
- FSM state enum.
- APSR bit indices (N=3, Z=2, C=1, V=0).

**Sub-module `regfile8x32`:** one write port, two combinational read ports (operand, debug), and synchronous reset to `RF_RESET`.

**ALU:** the ALU is instantiated alongside this block by the parent, not inside it.

## Test plan
1. **Reset then MOVS.** Reset, then bytes `0x21,0x5A` (MOVS r1,#0x5A). Require `RF[1]`=`0x5A`, `o_apsr`=`0000`, and `o_retire` at t+2.
2. **ADDS, zero result, wrap.** With r2=`0xFFFF_FFFF`, send `0x32,0x01` (ADDS r2,#1). Require `RF[2]`=0 and `o_apsr[2]`=1.
3. **CMP, negative.** With r3=5, send `0x2B,0x07` (CMP r3,#7). Require `RF[3]` unchanged at 5, `o_apsr[3]`=1, and `o_alu_sel`=`101` during `S_EXEC`.
4. **MOV reg.** With r1=`0x5A`, send `0x44,0x01` (MOV r4,r1). Require `RF[4]`=`0x5A`.
5. **Illegal opcode.** Send `0xF8,0x00`. Require `o_err` pulse at t+1, no RF/APSR change, and the next byte accepted at t+1.
6. **Stall and reset mid-instruction.**
   - Send hi `0x25`, then deassert valid for 4 cycles, then lo `0x10`. Require `RF[5]`=`0x10`.
   - Repeat with `i_rst` asserted in `S_LO`. Require no write, RF all `RF_RESET`, and state `S_HI`.
